uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART byte transmitter between `N_REQ` requesters. Each requester presents bytes on a valid/ready interface with a `last` flag marking the end of a message. The block grants one requester, holds the grant until that requester's message completes, and sequences the transmitter through start, busy and done for every byte. It sits between the command/loopback sources and the serial transmitter, in the transmitter's clock domain.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width.
- `ID_W`, $clog2(N_REQ): grant index width (derived).

- `clk` in 1: block clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: requester i has a byte.
- `req_data` in N_REQ*DATA_W: byte of requester i in bits [i*DATA_W +: DATA_W].
- `req_last` in N_REQ: byte of requester i ends its message.
- `req_ready` out N_REQ: one-hot, one-cycle accept pulse.
- `tx_data` out DATA_W: byte to the transmitter, registered.
- `tx_start` out 1: one-cycle launch pulse to the transmitter.
- `tx_busy` in 1: transmitter is shifting a frame.
- `grant_id` out ID_W: index of the current or last owner.
- `grant_active` out 1: a message lock is held.

## Operation
- State register values:
  - IDLE: no byte is in flight.
  - GRANT: `req_ready[g]`=1. Capture `req_data[g]` into `tx_data` and `req_last[g]` into `last_q`.
  - START: `tx_start`=1.
  - WAIT_BUSY: wait for `tx_busy`=1.
  - WAIT_DONE: wait for `tx_busy`=0.
- Transitions out of IDLE:
  - Unlocked and any `req_valid`: pick g with round-robin priority, searching upward from `ptr` with wrap N_REQ-1 to 0. Set lock and go to GRANT.
  - Locked: go to GRANT only when `req_valid[grant_id]`=1. Other requesters are ignored even if valid, so the owner may stall mid-message indefinitely.
- GRANT goes to START, and START goes to WAIT_BUSY unconditionally.
- WAIT_BUSY goes to WAIT_DONE when `tx_busy`=1.
- Leaving WAIT_DONE on `tx_busy`=0:
  - If `last_q`=1: clear the lock, set `ptr` to (grant_id+1) mod N_REQ, go to IDLE.
  - Else, if `req_valid[grant_id]`=1: go to GRANT, chaining bytes without an IDLE cycle.
  - Else: go to IDLE, still locked.
- A single-byte message is valid only with `req_last`=1 on that byte.
- `tx_data` holds its value from GRANT+1 until the next GRANT.
- `req_ready` is nonzero only in GRANT, and only bit `grant_id`. A transfer occurs on `req_valid & req_ready`, and `req_valid` is guaranteed high in GRANT.
- Requester data must stay stable while valid and not yet readied. The block does not check this.
- `tx_busy` high in IDLE or GRANT is ignored.
- Reset values, applied immediately and asynchronously: state=IDLE, `req_ready`=0, `tx_start`=0, `tx_data`=0, `grant_id`=0, `grant_active`=0, `ptr`=0, `last_q`=0. Reset mid-frame abandons the byte and the lock. The transmitter's own reset handles its line state.
- `ptr` wraps modulo N_REQ. For non-power-of-two N_REQ, indices at or above N_REQ are never produced.

## Timing
- Unlocked IDLE with `req_valid` sampled at edge k:
  - GRANT at k+1, so `req_ready` is high in cycle k+1.
  - `tx_start` high in cycle k+2, with `tx_data` already valid.
- Chained bytes: `tx_busy` falling seen at edge m, so GRANT at m+1 and `tx_start` at m+2.
- `grant_id` and `grant_active` update at the edge entering GRANT from unlocked IDLE. `grant_active` falls at the edge leaving WAIT_DONE with `last_q`=1.
- Simultaneous requests: exactly one grant, decided by `ptr`. A requester asserting valid while another holds the lock waits for that message's last byte.
- No timeout. If `tx_busy` never rises, the block waits forever in WAIT_BUSY. This is a documented integration requirement: the transmitter must assert busy within a bounded number of cycles after `tx_start`.

## Structure
- Package `uart_ctrl_pkg` holds:
  - the state enum (IDLE, GRANT, START, WAIT_BUSY, WAIT_DONE);
  - the `DATA_W` default constant;
  - the `ID_W` derivation.
- Sub-module `rr_arbiter`: combinational round-robin pick, taking the request vector and `ptr` and returning a one-hot grant, the encoded index and an `any` flag. It is reused by future shared-resource blocks.
- The top level holds the FSM, the lock and pointer registers, and the output registers. The byte mux is indexed by `grant_id`.

## Test plan
- **Single requester.** `req_valid[1]`=1, data 0x5A, last=1; transmitter model holds busy for 10 cycles.
  - `req_ready`=0b0010 at k+1.
  - `tx_start` at k+2 with `tx_data`=0x5A.
  - `grant_active` drops after busy falls; `ptr` becomes 2.
- **Round-robin fairness.** All four requesters hold valid continuously with single-byte messages.
  - Grant order 0,1,2,3,0.
  - Each `tx_start` carries that requester's byte (0x10+i).
- **Message lock.** Requester 2 sends 3 bytes (0xA1, 0xA2, 0xA3 with last on 0xA3) while requester 0 is valid throughout.
  - All three bytes go out before requester 0 is granted.
  - Requester 2 drops valid for 20 cycles between bytes 1 and 2: no other grant occurs and `grant_active` stays 1.
- **Chaining latency.** Back-to-back bytes of one message.
  - `tx_start` exactly 2 cycles after each busy falling edge.
- **Reset mid-operation.** Assert `rst_n`=0 during WAIT_DONE of a locked message.
  - All outputs reach reset values with no clock edge.
  - After release, requester 0 wins the first arbitration.
- **Spurious busy.** `tx_busy` pulses while IDLE with no requests.
  - No `req_ready` or `tx_start` is produced.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit-sharing control blocks.
//   arb_state_t    : sequencer states (IDLE, GRANT, START, WAIT_BUSY, WAIT_DONE)
//   DEFAULT_DATA_W : default byte width
//   id_width()     : grant-index width derived from the requester count
package uart_ctrl_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  // A single requester still needs a one-bit index so port widths stay legal.
  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter.
//   req_valid/req_data/req_last : per-requester byte offers (data packed i*DATA_W)
//   req_ready                   : one-hot accept pulse back to requesters
//   tx_data/tx_start/tx_busy    : shared byte transmitter handshake
//   grant_id/grant_active       : current or last owner and message-lock status
// Modport slave is the arbiter's view; master is the requesters'/transmitter's.
interface uart_tx_arbiter_if
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ID_W   = id_width(N_REQ)
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_start;
  logic                    tx_busy;
  logic [ID_W-1:0]         grant_id;
  logic                    grant_active;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_start, grant_id, grant_active
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_start, grant_id, grant_active
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index; search runs upward and wraps N_REQ-1 -> 0
//   gnt : one-hot grant, idx : encoded grant, any : some request present
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W-1:0] cand;

  // The modulo keeps candidates below N_REQ even when N_REQ is not a power of two.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = ID_W'((int'(ptr) + off) % N_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter among N_REQ requesters.
// A requester is chosen round-robin, keeps the grant until the byte flagged
// req_last has been sent, and each byte is walked through
// GRANT -> START -> WAIT_BUSY -> WAIT_DONE.
//   clk, rst_n : block clock, asynchronous active-low reset
//   bus        : uart_tx_arbiter_if.slave (requesters + transmitter handshake)
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int ID_W = id_width(N_REQ);

  arb_state_t        state;
  logic [ID_W-1:0]   ptr;
  logic              last_q;
  logic [N_REQ-1:0]  req_ready_q;
  logic              tx_start_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [ID_W-1:0]   grant_id_q;
  logic              grant_active_q;

  logic [N_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;

  logic [DATA_W-1:0] req_bytes [N_REQ];
  logic [DATA_W-1:0] owner_data;
  logic              owner_valid;
  logic              owner_last;
  logic [N_REQ-1:0]  owner_onehot;
  logic [ID_W-1:0]   ptr_next;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign req_bytes[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  assign owner_data   = req_bytes[grant_id_q];
  assign owner_valid  = bus.req_valid[grant_id_q];
  assign owner_last   = bus.req_last[grant_id_q];
  assign owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_q;
  assign ptr_next     = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

  // While the lock is held only the owner may re-enter GRANT; other valid
  // requesters wait until the owner's last byte has left the transmitter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      last_q         <= 1'b0;
      req_ready_q    <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!grant_active_q) begin
            if (arb_any) begin
              grant_id_q     <= arb_idx;
              grant_active_q <= 1'b1;
              req_ready_q    <= arb_gnt;
              state          <= GRANT;
            end
          end else if (owner_valid) begin
            req_ready_q <= owner_onehot;
            state       <= GRANT;
          end
        end
        GRANT: begin
          req_ready_q <= '0;
          tx_data_q   <= owner_data;
          last_q      <= owner_last;
          tx_start_q  <= 1'b1;
          state       <= START;
        end
        START: begin
          tx_start_q <= 1'b0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (last_q) begin
              grant_active_q <= 1'b0;
              ptr            <= ptr_next;
              state          <= IDLE;
            end else if (owner_valid) begin
              req_ready_q <= owner_onehot;
              state       <= GRANT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_active = grant_active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a transmitter model answers every
// tx_start with a busy frame, a monitor records each launched byte, and the
// main sequence compares those launches against an expected-byte queue.
module tb_uart_tx_arbiter;
  import uart_ctrl_pkg::*;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
    int         gap;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
    logic       active;
    int         gap;
  } obs_t;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         blen;
    logic [3:0] exp_ready;
  } vec_t;

  exp_t sb[$];
  obs_t obs[$];
  obs_t mon_o;
  vec_t vecs [4];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_fall_cyc = 0;
  int   busy_len = 10;
  logic model_busy = 1'b0;
  logic spur_busy  = 1'b0;

  assign bus.tx_busy = model_busy | spur_busy;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises one cycle after tx_start, lasts busy_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        @(negedge clk);
        model_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        model_busy = 1'b0;
        last_fall_cyc = cyc;
      end
    end
  end

  // Monitor: record every launched byte with cycles elapsed since busy last fell.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.tx_start === 1'b1) begin
      mon_o.data   = bus.tx_data;
      mon_o.id     = bus.grant_id;
      mon_o.active = bus.grant_active;
      mon_o.gap    = cyc - last_fall_cyc;
      obs.push_back(mon_o);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] data, input logic last);
    bus.req_valid[id]               = 1'b1;
    bus.req_data[id*DATA_W +: DATA_W] = data;
    bus.req_last[id]                = last;
  endtask

  task automatic dropReq(input int id);
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic sbPush(input int id, input logic [7:0] data, input int gap);
    exp_t e;
    e.id   = 2'(id);
    e.data = data;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic waitReady(input int id, input int budget, input string name);
    int n = 0;
    while (bus.req_ready[id] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " ready"}, 32'(bus.req_ready[id]), 32'd1);
  endtask

  // Offer a byte, wait for its accept pulse and step past the accepting edge.
  task automatic sendByte(input int id, input logic [7:0] data, input logic last, input int gap);
    applyStimulus(id, data, last);
    sbPush(id, data, gap);
    waitReady(id, 200, "send");
    @(posedge clk);
    #1;
    if (last) dropReq(id);
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while ((bus.grant_active !== 1'b0 || model_busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " idle reached"}, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic drainScoreboard(input string name);
    obs_t o;
    exp_t e;
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s unexpected tx_start: got data 0x%0h id %0d, expected none", name, o.data, o.id);
      end else begin
        e = sb.pop_front();
        checkOutput({name, " tx_data"}, 32'(o.data), 32'(e.data));
        checkOutput({name, " grant_id"}, 32'(o.id), 32'(e.id));
        checkOutput({name, " active at start"}, 32'(o.active), 32'd1);
        if (e.gap >= 0) checkOutput({name, " chain gap"}, 32'(o.gap), 32'(e.gap));
      end
    end
    checkOutput({name, " missing starts"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int mp;
    int cnt;
    int n;
    int n0;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;

    // Reset is asserted before any clock edge and must act immediately.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("reset tx_start", 32'(bus.tx_start), 32'd0);
    checkOutput("reset tx_data", 32'(bus.tx_data), 32'd0);
    checkOutput("reset grant_id", 32'(bus.grant_id), 32'd0);
    checkOutput("reset grant_active", 32'(bus.grant_active), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-byte messages from one requester at a time; the last leaves ptr at 2.
    vecs[0] = '{id: 3, data: 8'hC3, blen: 3,  exp_ready: 4'b1000};
    vecs[1] = '{id: 0, data: 8'h00, blen: 1,  exp_ready: 4'b0001};
    vecs[2] = '{id: 2, data: 8'hFF, blen: 5,  exp_ready: 4'b0100};
    vecs[3] = '{id: 1, data: 8'h5A, blen: 10, exp_ready: 4'b0010};
    for (int v = 0; v < 4; v++) begin
      busy_len = vecs[v].blen;
      applyStimulus(vecs[v].id, vecs[v].data, 1'b1);
      sbPush(vecs[v].id, vecs[v].data, -1);
      @(negedge clk);
      checkOutput("vec req_ready k+1", 32'(bus.req_ready), 32'(vecs[v].exp_ready));
      checkOutput("vec grant_id", 32'(bus.grant_id), 32'(vecs[v].id));
      checkOutput("vec grant_active", 32'(bus.grant_active), 32'd1);
      @(posedge clk);
      #1;
      dropReq(vecs[v].id);
      @(negedge clk);
      checkOutput("vec tx_start k+2", 32'(bus.tx_start), 32'd1);
      checkOutput("vec tx_data k+2", 32'(bus.tx_data), 32'(vecs[v].data));
      checkOutput("vec req_ready cleared", 32'(bus.req_ready), 32'd0);
      waitIdle(100, "vec");
      checkOutput("vec grant_id held", 32'(bus.grant_id), 32'(vecs[v].id));
    end
    drainScoreboard("vec");

    // With ptr at 2, requesters 1 and 2 together must resolve to 2 first.
    applyStimulus(1, 8'h61, 1'b1);
    applyStimulus(2, 8'h62, 1'b1);
    sbPush(2, 8'h62, -1);
    sbPush(1, 8'h61, -1);
    @(negedge clk);
    checkOutput("ptr probe req_ready", 32'(bus.req_ready), 32'b0100);
    @(posedge clk);
    #1;
    dropReq(2);
    waitReady(1, 200, "ptr probe second");
    @(posedge clk);
    #1;
    dropReq(1);
    waitIdle(200, "ptr probe");
    drainScoreboard("ptr probe");

    // All four requesters valid continuously with single-byte messages.
    doReset();
    busy_len = 4;
    for (int i = 0; i < N_REQ; i++) applyStimulus(i, 8'h10 + 8'(i), 1'b1);
    mp = 0;
    for (int k = 0; k < 5; k++) begin
      sbPush(mp, 8'h10 + 8'(mp), -1);
      mp = (mp + 1) % N_REQ;
    end
    cnt = 0;
    n   = 0;
    while (cnt < 5 && n < 500) begin
      @(negedge clk);
      n++;
      if (bus.req_ready !== '0) begin
        cnt++;
        checkOutput("fair one-hot", 32'($countones(bus.req_ready)), 32'd1);
      end
    end
    checkOutput("fair grant count", 32'(cnt), 32'd5);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    waitIdle(200, "fair");
    drainScoreboard("fair");

    // Requester 2 owns the lock across a 20-cycle stall while 0 waits.
    busy_len = 4;
    sendByte(2, 8'hA1, 1'b0, -1);
    dropReq(2);
    applyStimulus(0, 8'h55, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("lock grant_active", 32'(bus.grant_active), 32'd1);
      checkOutput("lock no req_ready", 32'(bus.req_ready), 32'd0);
    end
    sendByte(2, 8'hA2, 1'b0, -1);
    sendByte(2, 8'hA3, 1'b1, 2);
    sbPush(0, 8'h55, -1);
    waitReady(0, 200, "lock waiter");
    @(posedge clk);
    #1;
    dropReq(0);
    waitIdle(200, "lock");
    drainScoreboard("lock");

    // Back-to-back bytes: each chained launch two cycles after busy falls.
    busy_len = 5;
    sendByte(3, 8'h31, 1'b0, -1);
    sendByte(3, 8'h32, 1'b0, 2);
    sendByte(3, 8'h33, 1'b1, 2);
    waitIdle(200, "chain");
    drainScoreboard("chain");

    // Move ptr to 2, then reset while requester 2's message is in WAIT_DONE.
    busy_len = 3;
    sendByte(1, 8'h71, 1'b1, -1);
    waitIdle(200, "pre-reset");
    drainScoreboard("pre-reset");
    busy_len = 10;
    sendByte(2, 8'h81, 1'b0, -1);
    dropReq(2);
    n = 0;
    while (model_busy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reset-mid busy seen", 32'(model_busy), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("async tx_start", 32'(bus.tx_start), 32'd0);
    checkOutput("async tx_data", 32'(bus.tx_data), 32'd0);
    checkOutput("async grant_id", 32'(bus.grant_id), 32'd0);
    checkOutput("async grant_active", 32'(bus.grant_active), 32'd0);
    n = 0;
    while (model_busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    drainScoreboard("reset-mid");
    @(negedge clk);
    busy_len = 3;
    applyStimulus(0, 8'h90, 1'b1);
    applyStimulus(3, 8'h93, 1'b1);
    sbPush(0, 8'h90, -1);
    sbPush(3, 8'h93, -1);
    @(negedge clk);
    checkOutput("post-reset first grant", 32'(bus.req_ready), 32'b0001);
    @(posedge clk);
    #1;
    dropReq(0);
    waitReady(3, 200, "post-reset second");
    @(posedge clk);
    #1;
    dropReq(3);
    waitIdle(200, "post-reset");
    drainScoreboard("post-reset");

    // Busy pulses with nothing requested must not launch anything.
    n0 = obs.size();
    for (int p = 0; p < 3; p++) begin
      spur_busy = 1'b1;
      repeat (3) begin
        @(negedge clk);
        checkOutput("spurious req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("spurious tx_start", 32'(bus.tx_start), 32'd0);
      end
      spur_busy = 1'b0;
      repeat (2) @(negedge clk);
    end
    checkOutput("spurious launches", 32'(obs.size() - n0), 32'd0);
    checkOutput("spurious grant_active", 32'(bus.grant_active), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
